// File: rtl/gtfmac_vnc_sync_fifo_bram_if.sv
// Request/status bundle of the latency-record FIFO.
// The master drives the requests; the slave (the FIFO) drives data and status.
interface gtfmac_vnc_sync_fifo_bram_if #(
   parameter int DATA_WIDTH = 74,
   parameter int ADDR_WIDTH = 9
);
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] din;
   logic                  rd_en;
   logic                  clr_err;
   logic [DATA_WIDTH-1:0] dout;
   logic                  dout_vld;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   level;
   logic [ADDR_WIDTH:0]   max_level;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output wr_en, din, rd_en, clr_err,
      input  dout, dout_vld, full, empty, almost_full, almost_empty,
             level, max_level, overflow, underflow
   );

   modport slave (
      input  wr_en, din, rd_en, clr_err,
      output dout, dout_vld, full, empty, almost_full, almost_empty,
             level, max_level, overflow, underflow
   );
endinterface

// File: rtl/gtfmac_vnc_sync_fifo_bram.sv
// Single-clock FIFO on an inferred simple-dual-port RAM with level, thresholds,
// sticky error flags, high-water mark and optional first-word-fall-through output.
module gtfmac_vnc_sync_fifo_bram #(
   parameter int DATA_WIDTH    = 74,
   parameter int ADDR_WIDTH    = 9,
   parameter int AFULL_THRESH  = 480,
   parameter int AEMPTY_THRESH = 16,
   parameter int FWFT          = 1
)(
   input  logic clk,
   input  logic rstn,
   gtfmac_vnc_sync_fifo_bram_if.slave bus
);
   localparam int LW = ADDR_WIDTH + 1;
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
   localparam logic [LW-1:0] AF_L    = LW'(AFULL_THRESH);
   localparam logic [LW-1:0] AE_L    = LW'(AEMPTY_THRESH);

   logic [DATA_WIDTH-1:0] r_ram [DEPTH];
   logic [DATA_WIDTH-1:0] r_ram_q;
   logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
   logic [LW-1:0]         r_ram_cnt, r_level, r_max_level;
   logic                  r_s1_vld, r_full, r_empty, r_afull, r_aempty;
   logic                  r_overflow, r_underflow;

   logic                  w_wr_acc, w_rd_acc, w_ram_rd, w_out_load;
   logic                  w_dout_vld, w_s1_vld_next, w_dout_vld_next, w_empty_next;
   logic [LW-1:0]         w_ram_cnt_next, w_level_next, w_max_base, w_max_next;

   // r_ram_cnt counts words still in the array; r_level also counts the
   // prefetch register and output register in FWFT mode.
   always_comb begin
      w_wr_acc        = bus.wr_en && !r_full;
      w_rd_acc        = bus.rd_en && !r_empty;
      w_out_load      = 1'b0;
      w_ram_rd        = 1'b0;
      w_s1_vld_next   = r_s1_vld;
      w_dout_vld_next = w_dout_vld;
      if (FWFT != 0) begin
         w_out_load = r_s1_vld && (!w_dout_vld || w_rd_acc);
         w_ram_rd   = (r_ram_cnt != '0) && (!r_s1_vld || w_out_load);
         if (w_ram_rd)
            w_s1_vld_next = 1'b1;
         else if (w_out_load)
            w_s1_vld_next = 1'b0;
         if (w_out_load)
            w_dout_vld_next = 1'b1;
         else if (w_rd_acc)
            w_dout_vld_next = 1'b0;
      end else begin
         w_ram_rd        = w_rd_acc;
         w_s1_vld_next   = w_rd_acc;
         w_dout_vld_next = w_rd_acc;
      end
      w_ram_cnt_next = r_ram_cnt + LW'(w_wr_acc) - LW'(w_ram_rd);
      w_level_next   = r_level + LW'(w_wr_acc) - LW'(w_rd_acc);
      w_empty_next   = (FWFT != 0) ? !w_dout_vld_next : (w_level_next == '0);
      w_max_base     = bus.clr_err ? '0 : r_max_level;
      w_max_next     = (w_level_next > w_max_base) ? w_level_next : w_max_base;
   end

   // Array write port kept free of reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (w_wr_acc)
         r_ram[r_wr_ptr] <= bus.din;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_ram_cnt   <= '0;
         r_level     <= '0;
         r_max_level <= '0;
         r_ram_q     <= '0;
         r_s1_vld    <= 1'b0;
         r_full      <= 1'b0;
         r_empty     <= 1'b1;
         r_afull     <= 1'b0;
         r_aempty    <= 1'b1;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_ram_rd) begin
            r_ram_q  <= r_ram[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
         end
         if (w_wr_acc)
            r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
         r_ram_cnt   <= w_ram_cnt_next;
         r_level     <= w_level_next;
         r_max_level <= w_max_next;
         r_s1_vld    <= w_s1_vld_next;
         r_full      <= (w_level_next == DEPTH_L);
         r_empty     <= w_empty_next;
         r_afull     <= (w_level_next >= AF_L);
         r_aempty    <= (w_level_next <= AE_L);
         // A fresh error in the clearing cycle keeps the flag set.
         r_overflow  <= (r_overflow && !bus.clr_err) || (bus.wr_en && r_full);
         r_underflow <= (r_underflow && !bus.clr_err) || (bus.rd_en && r_empty);
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         logic [DATA_WIDTH-1:0] r_dout;
         logic                  r_dout_vld;
         always_ff @(posedge clk) begin
            if (!rstn) begin
               r_dout     <= '0;
               r_dout_vld <= 1'b0;
            end else begin
               if (w_out_load)
                  r_dout <= r_ram_q;
               r_dout_vld <= w_dout_vld_next;
            end
         end
         assign w_dout_vld   = r_dout_vld;
         assign bus.dout     = r_dout;
         assign bus.dout_vld = r_dout_vld;
      end else begin : g_std
         assign w_dout_vld   = r_s1_vld;
         assign bus.dout     = r_ram_q;
         assign bus.dout_vld = r_s1_vld;
      end
   endgenerate

   assign bus.full         = r_full;
   assign bus.empty        = r_empty;
   assign bus.almost_full  = r_afull;
   assign bus.almost_empty = r_aempty;
   assign bus.level        = r_level;
   assign bus.max_level    = r_max_level;
   assign bus.overflow     = r_overflow;
   assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_gtfmac_vnc_sync_fifo_bram.sv
// Drives an FWFT instance and a standard-mode instance with identical stimulus
// and compares both against queue-based models of the FIFO behaviour.
module tb_gtfmac_vnc_sync_fifo_bram;
   localparam int DW = 74;
   localparam int AW = 9;
   localparam int LW = AW + 1;
   localparam int DEPTH = 512;
   localparam int AF = 480;
   localparam int AE = 16;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
   logic [DW-1:0] din = '0;

   always #5 clk = ~clk;

   gtfmac_vnc_sync_fifo_bram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bf ();
   gtfmac_vnc_sync_fifo_bram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bs ();

   assign bf.wr_en = wr_en;  assign bf.din = din;  assign bf.rd_en = rd_en;  assign bf.clr_err = clr_err;
   assign bs.wr_en = wr_en;  assign bs.din = din;  assign bs.rd_en = rd_en;  assign bs.clr_err = clr_err;

   gtfmac_vnc_sync_fifo_bram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AF),
      .AEMPTY_THRESH(AE), .FWFT(1)) dut_f (.clk(clk), .rstn(rstn), .bus(bf));
   gtfmac_vnc_sync_fifo_bram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AF),
      .AEMPTY_THRESH(AE), .FWFT(0)) dut_s (.clk(clk), .rstn(rstn), .bus(bs));

   // Reference model: queues of stored words. An FWFT front word is shown
   // two edges after its write, or at the edge that pops its predecessor.
   typedef struct { logic [DW-1:0] data; int wedge; } ent_t;
   ent_t          qf[$];
   ent_t          qs[$];
   int            edge_n = 0;
   int            mf_avail = 0;
   logic          mf_vld = 0, ms_vld = 0, mf_ovf = 0, mf_udf = 0, ms_ovf = 0, ms_udf = 0;
   logic [DW-1:0] mf_dout = '0, ms_dout = '0;
   int            mf_max = 0, ms_max = 0;
   int            n_cmp = 0, n_err = 0;

   function automatic logic [DW-1:0] rnd_word();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[DW-1:0];
   endfunction

   function automatic logic [6:0] exp_flags_f();
      return {qf.size() == DEPTH, !mf_vld, qf.size() >= AF, qf.size() <= AE, mf_ovf, mf_udf, mf_vld};
   endfunction

   function automatic logic [6:0] exp_flags_s();
      return {qs.size() == DEPTH, qs.size() == 0, qs.size() >= AF, qs.size() <= AE, ms_ovf, ms_udf, ms_vld};
   endfunction

   task automatic model_edge();
      logic f_full, f_empty, s_full, s_empty, f_wa, f_ra, s_wa, s_ra;
      ent_t e;
      if (!rstn) begin
         qf.delete(); qs.delete();
         mf_vld = 0; ms_vld = 0; mf_ovf = 0; mf_udf = 0; ms_ovf = 0; ms_udf = 0;
         mf_dout = '0; ms_dout = '0; mf_max = 0; ms_max = 0;
      end else begin
         e.data = din; e.wedge = edge_n;
         // FWFT instance
         f_full = (qf.size() == DEPTH); f_empty = !mf_vld;
         f_wa = wr_en && !f_full; f_ra = rd_en && !f_empty;
         mf_ovf = (mf_ovf && !clr_err) || (wr_en && f_full);
         mf_udf = (mf_udf && !clr_err) || (rd_en && f_empty);
         if (f_ra) begin
            void'(qf.pop_front());
            if (qf.size() > 0) mf_avail = (qf[0].wedge + 2 > edge_n) ? qf[0].wedge + 2 : edge_n;
         end
         if (f_wa) begin
            if (qf.size() == 0) mf_avail = edge_n + 2;
            qf.push_back(e);
         end
         mf_vld = (qf.size() > 0) && (edge_n >= mf_avail);
         if (mf_vld) mf_dout = qf[0].data;
         if (clr_err) mf_max = 0;
         if (qf.size() > mf_max) mf_max = qf.size();
         // standard instance
         s_full = (qs.size() == DEPTH); s_empty = (qs.size() == 0);
         s_wa = wr_en && !s_full; s_ra = rd_en && !s_empty;
         ms_ovf = (ms_ovf && !clr_err) || (wr_en && s_full);
         ms_udf = (ms_udf && !clr_err) || (rd_en && s_empty);
         ms_vld = s_ra;
         if (s_ra) ms_dout = qs.pop_front().data;
         if (s_wa) qs.push_back(e);
         if (clr_err) ms_max = 0;
         if (qs.size() > ms_max) ms_max = qs.size();
      end
      edge_n++;
   endtask

   task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
      wr_en = w; din = d; rd_en = r; clr_err = c;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      step(0, '0, 0, 0);
      step(0, '0, 0, 0);
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if ({bf.full, bf.empty, bf.almost_full, bf.almost_empty, bf.overflow, bf.underflow, bf.dout_vld} !== 7'b0101000) begin n_err++; $display("FAIL reset.fwft.flags got %b want 0101000", {bf.full, bf.empty, bf.almost_full, bf.almost_empty, bf.overflow, bf.underflow, bf.dout_vld}); end
      n_cmp++; if ({bs.full, bs.empty, bs.almost_full, bs.almost_empty, bs.overflow, bs.underflow, bs.dout_vld} !== 7'b0101000) begin n_err++; $display("FAIL reset.std.flags got %b want 0101000", {bs.full, bs.empty, bs.almost_full, bs.almost_empty, bs.overflow, bs.underflow, bs.dout_vld}); end
      n_cmp++; if ({bf.level, bf.max_level, bs.level, bs.max_level} !== '0) begin n_err++; $display("FAIL reset.levels got %0d/%0d %0d/%0d want 0", bf.level, bf.max_level, bs.level, bs.max_level); end
      n_cmp++; if (bf.dout !== '0 || bs.dout !== '0) begin n_err++; $display("FAIL reset.dout got %0h %0h want 0", bf.dout, bs.dout); end
      $display("test_reset: done, %0d compared so far", n_cmp);
   endtask

   task automatic test_fwft_fill();
      for (int i = 1; i <= 4; i++) begin
         step(1, DW'(i), 0, 0);
         if (i < 3) begin
            n_cmp++; if (bf.dout_vld !== 1'b0) begin n_err++; $display("FAIL fill.early_vld w%0d got %b want 0", i, bf.dout_vld); end
         end else begin
            n_cmp++; if (bf.dout_vld !== 1'b1 || bf.dout !== DW'(1)) begin n_err++; $display("FAIL fill.first_word w%0d got vld=%b dout=%0h want vld=1 dout=1", i, bf.dout_vld, bf.dout); end
         end
      end
      n_cmp++; if (bf.level !== LW'(4) || bf.almost_empty !== 1'b1) begin n_err++; $display("FAIL fill.fwft_level got %0d ae=%b want 4 ae=1", bf.level, bf.almost_empty); end
      n_cmp++; if (bs.level !== LW'(4) || bs.dout_vld !== 1'b0) begin n_err++; $display("FAIL fill.std_level got %0d vld=%b want 4 vld=0", bs.level, bs.dout_vld); end
      $display("test_fwft_fill: done, %0d compared so far", n_cmp);
   endtask

   task automatic test_drain();
      for (int i = 1; i <= 4; i++) begin
         n_cmp++; if (bf.dout_vld !== 1'b1 || bf.dout !== DW'(i)) begin n_err++; $display("FAIL drain.fwft_word%0d got vld=%b dout=%0h want vld=1 dout=%0h", i, bf.dout_vld, bf.dout, i); end
         step(0, '0, 1, 0);
         n_cmp++; if (bs.dout_vld !== 1'b1 || bs.dout !== DW'(i)) begin n_err++; $display("FAIL drain.std_word%0d got vld=%b dout=%0h want vld=1 dout=%0h", i, bs.dout_vld, bs.dout, i); end
      end
      n_cmp++; if ({bf.empty, bf.underflow, bs.empty, bs.underflow} !== 4'b1010 || bf.level !== '0 || bs.level !== '0) begin n_err++; $display("FAIL drain.end got e/u=%b levels %0d %0d want 1010 0 0", {bf.empty, bf.underflow, bs.empty, bs.underflow}, bf.level, bs.level); end
      $display("test_drain: done, %0d compared so far", n_cmp);
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= DEPTH; i++) begin
         step(1, rnd_word(), 0, 0);
         if (i == AF - 1 || i == AF) begin
            n_cmp++; if (bf.almost_full !== (i >= AF) || bs.almost_full !== (i >= AF)) begin n_err++; $display("FAIL ovf.afull_at_%0d got %b %b want %b", i, bf.almost_full, bs.almost_full, i >= AF); end
         end
         if (i == DEPTH - 1) begin
            n_cmp++; if (bf.full !== 1'b0 || bs.full !== 1'b0) begin n_err++; $display("FAIL ovf.full_at_511 got %b %b want 0", bf.full, bs.full); end
         end
      end
      n_cmp++; if (bf.full !== 1'b1 || bs.full !== 1'b1 || bf.level !== LW'(DEPTH)) begin n_err++; $display("FAIL ovf.full_before got %b %b lvl=%0d want 1 1 512", bf.full, bs.full, bf.level); end
      step(1, rnd_word(), 1, 0);
      n_cmp++; if ({bf.overflow, bs.overflow, bf.full, bs.full} !== 4'b1100) begin n_err++; $display("FAIL ovf.flags got %b want 1100", {bf.overflow, bs.overflow, bf.full, bs.full}); end
      n_cmp++; if (bf.level !== LW'(DEPTH - 1) || bs.level !== LW'(DEPTH - 1)) begin n_err++; $display("FAIL ovf.level got %0d %0d want 511", bf.level, bs.level); end
      n_cmp++; if (bf.max_level !== LW'(DEPTH) || bs.max_level !== LW'(DEPTH)) begin n_err++; $display("FAIL ovf.max got %0d %0d want 512", bf.max_level, bs.max_level); end
      for (int i = 0; i < DEPTH + 3; i++) begin
         step(0, '0, 1, 0);
         n_cmp++; if (bf.dout !== mf_dout || bf.dout_vld !== mf_vld) begin n_err++; $display("FAIL ovf.drain_fwft cyc%0d got %b/%0h want %b/%0h", i, bf.dout_vld, bf.dout, mf_vld, mf_dout); end
         n_cmp++; if (bs.dout !== ms_dout || bs.dout_vld !== ms_vld) begin n_err++; $display("FAIL ovf.drain_std cyc%0d got %b/%0h want %b/%0h", i, bs.dout_vld, bs.dout, ms_vld, ms_dout); end
      end
      n_cmp++; if (bf.level !== '0 || bs.level !== '0 || bf.empty !== 1'b1) begin n_err++; $display("FAIL ovf.drained got %0d %0d e=%b want 0 0 1", bf.level, bs.level, bf.empty); end
      $display("test_overflow: done, %0d compared so far", n_cmp);
   endtask

   task automatic test_back_to_back();
      int exp_f, exp_s;
      do_reset();
      for (int i = 0; i < 8; i++) step(1, DW'(100 + i), 0, 0);
      repeat (3) step(0, '0, 0, 0);
      exp_f = 100; exp_s = 100;
      for (int i = 0; i < 1500; i++) begin
         n_cmp++; if (bf.dout_vld !== 1'b1 || bf.dout !== DW'(exp_f) || bf.level !== LW'(8)) begin n_err++; $display("FAIL b2b.fwft cyc%0d got vld=%b dout=%0d lvl=%0d want 1 %0d 8", i, bf.dout_vld, bf.dout, bf.level, exp_f); end
         step(1, DW'(108 + i), 1, 0);
         exp_f++;
         n_cmp++; if (bs.dout_vld !== 1'b1 || bs.dout !== DW'(exp_s) || bs.level !== LW'(8)) begin n_err++; $display("FAIL b2b.std cyc%0d got vld=%b dout=%0d lvl=%0d want 1 %0d 8", i, bs.dout_vld, bs.dout, bs.level, exp_s); end
         exp_s++;
      end
      $display("test_back_to_back: done, %0d compared so far", n_cmp);
   endtask

   task automatic test_underflow();
      do_reset();
      step(0, '0, 1, 0);
      n_cmp++; if (bf.underflow !== 1'b1 || bs.underflow !== 1'b1 || bf.level !== '0 || bs.level !== '0) begin n_err++; $display("FAIL udf.set got %b %b lvl %0d %0d want 1 1 0 0", bf.underflow, bs.underflow, bf.level, bs.level); end
      step(0, '0, 1, 1);
      n_cmp++; if (bf.underflow !== 1'b1 || bs.underflow !== 1'b1) begin n_err++; $display("FAIL udf.clr_vs_new got %b %b want 1 1", bf.underflow, bs.underflow); end
      step(0, '0, 0, 1);
      n_cmp++; if (bf.underflow !== 1'b0 || bs.underflow !== 1'b0 || bf.max_level !== '0) begin n_err++; $display("FAIL udf.clear got %b %b max=%0d want 0 0 0", bf.underflow, bs.underflow, bf.max_level); end
      $display("test_underflow: done, %0d compared so far", n_cmp);
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] w;
      do_reset();
      for (int i = 0; i < 200; i++) step(1, rnd_word(), 0, 0);
      n_cmp++; if (bf.level !== LW'(200) || bs.level !== LW'(200)) begin n_err++; $display("FAIL rstmid.level200 got %0d %0d want 200", bf.level, bs.level); end
      rstn = 1'b0;
      step(1, rnd_word(), 0, 0);
      rstn = 1'b1;
      n_cmp++; if ({bf.full, bf.empty, bf.almost_full, bf.almost_empty, bf.overflow, bf.underflow, bf.dout_vld} !== 7'b0101000 || bf.level !== '0 || bf.max_level !== '0) begin n_err++; $display("FAIL rstmid.fwft got flags=%b lvl=%0d max=%0d want 0101000 0 0", {bf.full, bf.empty, bf.almost_full, bf.almost_empty, bf.overflow, bf.underflow, bf.dout_vld}, bf.level, bf.max_level); end
      n_cmp++; if ({bs.full, bs.empty, bs.almost_full, bs.almost_empty, bs.overflow, bs.underflow, bs.dout_vld} !== 7'b0101000 || bs.level !== '0 || bs.max_level !== '0) begin n_err++; $display("FAIL rstmid.std got flags=%b lvl=%0d max=%0d want 0101000 0 0", {bs.full, bs.empty, bs.almost_full, bs.almost_empty, bs.overflow, bs.underflow, bs.dout_vld}, bs.level, bs.max_level); end
      w = rnd_word();
      step(1, w, 0, 0);
      step(0, '0, 1, 0);
      n_cmp++; if (bs.dout_vld !== 1'b1 || bs.dout !== w || bs.level !== '0) begin n_err++; $display("FAIL rstmid.pop got vld=%b dout=%0h lvl=%0d want 1 %0h 0", bs.dout_vld, bs.dout, bs.level, w); end
      n_cmp++; if (bf.underflow !== mf_udf || bf.level !== LW'(qf.size())) begin n_err++; $display("FAIL rstmid.fwft_early_rd got u=%b lvl=%0d want %b %0d", bf.underflow, bf.level, mf_udf, qf.size()); end
      step(0, '0, 0, 0);
      n_cmp++; if (bs.dout_vld !== 1'b0 || bs.dout !== w) begin n_err++; $display("FAIL rstmid.pulse got vld=%b dout=%0h want 0 %0h", bs.dout_vld, bs.dout, w); end
      $display("test_reset_mid: done, %0d compared so far", n_cmp);
   endtask

   task automatic test_random();
      int wp[4] = '{92, 50, 15, 60};
      int rp[4] = '{25, 50, 90, 55};
      do_reset();
      for (int ph = 0; ph < 4; ph++) begin
         for (int i = 0; i < 700; i++) begin
            step($urandom_range(99) < wp[ph], rnd_word(), $urandom_range(99) < rp[ph], $urandom_range(199) == 0);
            n_cmp++; if ({bf.full, bf.empty, bf.almost_full, bf.almost_empty, bf.overflow, bf.underflow, bf.dout_vld} !== exp_flags_f()) begin n_err++; $display("FAIL rand.fwft_flags ph%0d cyc%0d got %b want %b", ph, i, {bf.full, bf.empty, bf.almost_full, bf.almost_empty, bf.overflow, bf.underflow, bf.dout_vld}, exp_flags_f()); end
            n_cmp++; if (bf.level !== LW'(qf.size()) || bf.max_level !== LW'(mf_max) || bf.dout !== mf_dout) begin n_err++; $display("FAIL rand.fwft_data ph%0d cyc%0d got %0d/%0d/%0h want %0d/%0d/%0h", ph, i, bf.level, bf.max_level, bf.dout, qf.size(), mf_max, mf_dout); end
            n_cmp++; if ({bs.full, bs.empty, bs.almost_full, bs.almost_empty, bs.overflow, bs.underflow, bs.dout_vld} !== exp_flags_s()) begin n_err++; $display("FAIL rand.std_flags ph%0d cyc%0d got %b want %b", ph, i, {bs.full, bs.empty, bs.almost_full, bs.almost_empty, bs.overflow, bs.underflow, bs.dout_vld}, exp_flags_s()); end
            n_cmp++; if (bs.level !== LW'(qs.size()) || bs.max_level !== LW'(ms_max) || bs.dout !== ms_dout) begin n_err++; $display("FAIL rand.std_data ph%0d cyc%0d got %0d/%0d/%0h want %0d/%0d/%0h", ph, i, bs.level, bs.max_level, bs.dout, qs.size(), ms_max, ms_dout); end
         end
      end
      $display("test_random: done, %0d compared so far", n_cmp);
   endtask

   initial begin
      test_reset();
      test_fwft_fill();
      test_drain();
      test_overflow();
      test_back_to_back();
      test_underflow();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/gtfmac_vnc_sync_fifo_bram.md
Name: gtfmac_vnc_sync_fifo_bram

Overview:
Single-clock FIFO built on an inferred simple-dual-port block RAM, for buffering timestamp/latency records inside the GTF latency-measurement datapath.
- Generalises the plain BRAM primitive with pointer management, fill level, and full/empty/almost thresholds.
- Selectable standard or first-word-fall-through (FWFT) read mode.
- Sticky overflow/underflow error flags and a high-water-mark register for debug.

Parameters:
DATA_WIDTH, 74, word width in bits.
ADDR_WIDTH, 9, RAM address width; depth is 2**ADDR_WIDTH.
AFULL_THRESH, 480, almost_full asserts when level >= this value.
AEMPTY_THRESH, 16, almost_empty asserts when level <= this value.
FWFT, 1, 1 = first-word-fall-through, 0 = standard read.

Ports:
clk  in  1  single clock; all logic is on the rising edge.
rstn  in  1  synchronous active-low reset.
wr_en  in  1  write request.
din  in  DATA_WIDTH  write data.
rd_en  in  1  read (pop) request.
dout  out  DATA_WIDTH  read data.
dout_vld  out  1  dout holds a valid word.
full  out  1  level == 2**ADDR_WIDTH.
empty  out  1  no word available to read.
almost_full  out  1  level >= AFULL_THRESH.
almost_empty  out  1  level <= AEMPTY_THRESH.
level  out  ADDR_WIDTH+1  words held, including any FWFT prefetch stage.
max_level  out  ADDR_WIDTH+1  high-water mark of level.
overflow  out  1  sticky: a write was attempted while full.
underflow  out  1  sticky: a read was attempted while empty.
clr_err  in  1  clears overflow, underflow and max_level.

Behaviour:
- Reset (rstn=0 at an edge):
  - Pointers = 0, level = 0, max_level = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - dout = 0, dout_vld = 0, overflow = 0, underflow = 0.
  - RAM contents are not reset.
  - Reset mid-operation discards all stored words; the first write after reset lands at address 0.
- All flags and level are registered.
  - The full/empty values in force before an edge qualify that edge's requests.
- Write: wr_en && !full stores din at wr_ptr; wr_ptr increments modulo 2**ADDR_WIDTH (natural wrap).
  - wr_en && full: word dropped, pointers unchanged, overflow <= 1.
  - This holds even if rd_en is asserted in the same cycle.
- Standard mode (FWFT=0):
  - rd_en && !empty reads ram[rd_ptr]; dout updates and dout_vld pulses for exactly 1 cycle after the edge (1-cycle latency).
  - rd_ptr increments; otherwise dout holds its value and dout_vld = 0.
  - empty = (level == 0).
- FWFT mode (FWFT=1):
  - Internal prefetch pipeline: RAM read stage plus output register.
  - A word written at edge k into an empty FIFO gives dout_vld = 1 with dout = that word after edge k+2.
  - dout/dout_vld hold until rd_en is sampled high with dout_vld = 1; that edge pops the word.
  - The next word, if present in RAM, appears after the same edge, so back-to-back pops sustain 1 word/cycle.
  - empty = !dout_vld.
- Underflow: rd_en && empty (either mode) leaves state unchanged and sets underflow <= 1.
- Level:
  - Accepted write only: +1.
  - Accepted pop only: -1.
  - Both accepted: unchanged.
  - Level never exceeds 2**ADDR_WIDTH and never goes below 0.
- Simultaneous accepted read and write at level 0 (standard mode): the read is rejected as underflow (empty=1 pre-edge) and the write is accepted.
- almost_full, almost_empty and full are derived from the next-state level, registered.
- max_level <= max(max_level, next level) every cycle.
- clr_err: clears overflow, underflow and max_level at the next edge.
  - A new overflow/underflow event in the same cycle wins: the flag ends set.
  - max_level loads the next level rather than 0.
- RAM read-during-write to the same address cannot occur for accepted operations; the pointers guarantee separation.

Test Plan:
1. Reset, then write 0x1..0x4 on 4 consecutive cycles, FWFT=1 -> dout=0x1 with dout_vld=1 two cycles after the first write; level=4; almost_empty=1.
2. FWFT=1, rd_en held high 4 cycles -> dout 0x1, 0x2, 0x3, 0x4 on consecutive cycles; then empty=1, level=0, underflow=0.
3. Write 512 words, then a 513th with rd_en=1 in the same cycle -> 513th dropped; overflow=1; full=1 before that edge; level=511 after; max_level=512; almost_full asserted from level 480.
4. Continuous write+read for 1500 cycles with incrementing data -> pointers wrap twice; output sequence gap-free and in order; level constant.
5. rd_en on an empty FIFO -> underflow=1, level=0. clr_err pulsed together with a second empty read -> underflow stays 1. clr_err alone next cycle -> underflow=0.
6. Assert rstn=0 at level 200, mid-burst -> next cycle: level=0, empty=1, dout_vld=0, flags cleared. A subsequent single write followed by a pop (FWFT=0) returns that word with dout_vld pulsing for 1 cycle.
